// File: rtl/acc_operand_feeder.sv
// acc_operand_feeder: FIFO-buffered operand feeder for the signed accumulator with shadow sum and overflow flag
module acc_operand_feeder #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             flush,
    input  logic             clear_ovf,
    output logic [WIDTH-1:0] acc_in,
    output logic             acc_strobe,
    output logic [AW:0]      level,
    output logic [WIDTH-1:0] shadow_sum,
    output logic             ovf_sticky
);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr, rd_ptr;
    logic [WIDTH-1:0] sum;
    logic             push, pop, ovf;
    assign level    = wr_ptr - rd_ptr;
    assign in_ready = level != (AW+1)'(DEPTH);
    assign push     = in_valid & in_ready & ~flush;
    assign pop      = (level != '0) & ~flush;
    assign sum      = shadow_sum + acc_in;
    // signed overflow: equal-sign addends producing a result of the other sign
    assign ovf      = (shadow_sum[WIDTH-1] == acc_in[WIDTH-1]) & (sum[WIDTH-1] != shadow_sum[WIDTH-1]);
    always_ff @(posedge clk)
        if (push)
            mem[wr_ptr[AW-1:0]] <= in_data;
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            acc_in     <= '0;
            acc_strobe <= 1'b0;
            shadow_sum <= '0;
            ovf_sticky <= 1'b0;
        end else begin
            wr_ptr     <= flush ? '0 : wr_ptr + (AW+1)'(push);
            rd_ptr     <= flush ? '0 : rd_ptr + (AW+1)'(pop);
            acc_in     <= pop ? mem[rd_ptr[AW-1:0]] : '0;
            acc_strobe <= pop;
            shadow_sum <= sum;
            ovf_sticky <= ovf | (ovf_sticky & ~clear_ovf);
        end
    end
endmodule

// File: tb/tb_acc_operand_feeder.sv
// tb_acc_operand_feeder: randomized and directed checks of acc_operand_feeder against a queue-based model
module tb_acc_operand_feeder;
    logic              clk = 0;
    logic              rst_n = 0;
    logic signed [7:0] in_data = 0;
    logic              in_valid = 0;
    logic              in_ready;
    logic              flush = 0;
    logic              clear_ovf = 0;
    logic [7:0]        acc_in;
    logic              acc_strobe;
    logic [2:0]        level;
    logic [7:0]        shadow_sum;
    logic              ovf_sticky;

    int                errors = 0;
    int                checks = 0;
    int                q[$];
    logic signed [7:0] m_acc = 0;
    logic              m_strobe = 0;
    logic signed [7:0] m_shadow = 0;
    logic              m_ovf = 0;

    acc_operand_feeder dut (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .flush(flush), .clear_ovf(clear_ovf), .acc_in(acc_in), .acc_strobe(acc_strobe),
        .level(level), .shadow_sum(shadow_sum), .ovf_sticky(ovf_sticky)
    );

    always #5 clk = ~clk;

    wire [21:0] got = {acc_in, acc_strobe, level, shadow_sum, ovf_sticky, in_ready};

    function automatic logic [21:0] want();
        return {m_acc, m_strobe, 3'(q.size()), m_shadow, m_ovf, q.size() != 4};
    endfunction

    // Advance the model by one edge from the currently driven inputs, then clock the DUT.
    task automatic step();
        int s;
        bit ready;
        ready = q.size() != 4;
        s = int'(m_shadow) + int'(m_acc);
        if (!rst_n) begin
            q.delete();
            m_acc = 0; m_strobe = 0; m_shadow = 0; m_ovf = 0;
        end else begin
            m_ovf = (s > 127 || s < -128) ? 1'b1 : clear_ovf ? 1'b0 : m_ovf;
            m_shadow = 8'(s);
            if (flush) begin
                q.delete();
                m_acc = 0; m_strobe = 0;
            end else begin
                if (q.size() > 0) begin
                    m_acc = 8'(q.pop_front());
                    m_strobe = 1;
                end else begin
                    m_acc = 0; m_strobe = 0;
                end
                if (in_valid && ready) q.push_back(int'(in_data));
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        in_valid = 0; flush = 0; clear_ovf = 0; rst_n = 1;
    endtask

    task automatic test_reset();
        rst_n = 0; in_valid = 0; flush = 0; clear_ovf = 0;
        repeat (2) step();
        checks++;
        if (got !== 22'h000001) begin errors++; $display("FAIL reset got=%h want=000001", got); end
        rst_n = 1;
        repeat (5) begin
            step();
            checks++;
            if (got !== want()) begin errors++; $display("FAIL reset_idle got=%h want=%h", got, want()); end
        end
        checks++;
        if (acc_in !== 0 || acc_strobe !== 0 || level !== 0 || in_ready !== 1 || shadow_sum !== 0) begin
            errors++; $display("FAIL idle_values got=%h want=000001", got);
        end
    endtask

    task automatic test_sequence();
        logic signed [7:0] pushes [4] = '{8'sd10, 8'sd20, 8'sd127, -8'sd50};
        logic signed [7:0] exp_acc [7] = '{0, 10, 20, 127, -50, 0, 0};
        logic signed [7:0] exp_sum [7] = '{0, 0, 10, 30, -99, 107, 107};
        idle();
        for (int i = 0; i < 7; i++) begin
            in_valid = i < 4;
            in_data = i < 4 ? pushes[i] : 8'sd0;
            step();
            checks++;
            if (got !== want()) begin errors++; $display("FAIL seq_model step=%0d got=%h want=%h", i, got, want()); end
            checks++;
            if ($signed(acc_in) !== exp_acc[i] || $signed(shadow_sum) !== exp_sum[i]) begin
                errors++;
                $display("FAIL seq_values step=%0d acc_in=%0d want=%0d shadow=%0d want=%0d",
                         i, $signed(acc_in), exp_acc[i], $signed(shadow_sum), exp_sum[i]);
            end
            if (i == 4) begin
                checks++;
                if (ovf_sticky !== 1) begin errors++; $display("FAIL seq_ovf got=%b want=1", ovf_sticky); end
            end
        end
    endtask

    task automatic test_full_flush();
        idle();
        for (int i = 0; i < 40; i++) begin
            in_valid = $urandom_range(0, 3) != 0;
            in_data = 8'($urandom);
            step();
            checks++;
            if (level > 4 || in_ready !== (level != 4) || got !== want()) begin
                errors++; $display("FAIL full_level step=%0d got=%h want=%h", i, got, want());
            end
        end
        in_valid = 1; in_data = 9; flush = 1;
        step();
        checks++;
        if (level !== 0 || acc_in !== 0 || acc_strobe !== 0 || got !== want()) begin
            errors++; $display("FAIL flush got=%h want=%h", got, want());
        end
        idle();
        repeat (3) begin
            step();
            checks++;
            if (acc_strobe !== 0 || acc_in === 9 || got !== want()) begin
                errors++; $display("FAIL flush_drop got=%h want=%h", got, want());
            end
        end
    endtask

    task automatic test_wrap();
        int seen[$];
        idle();
        for (int i = 0; i < 9; i++) begin
            in_valid = i < 5;
            in_data = 8'(i + 3);
            step();
            if (acc_strobe) seen.push_back(int'($signed(acc_in)));
            checks++;
            if (got !== want()) begin errors++; $display("FAIL wrap_model step=%0d got=%h want=%h", i, got, want()); end
        end
        checks++;
        if (seen.size() != 5 || seen[0] != 3 || seen[1] != 4 || seen[2] != 5 || seen[3] != 6 || seen[4] != 7) begin
            errors++; $display("FAIL wrap_order got=%p want=3,4,5,6,7", seen);
        end
    endtask

    task automatic test_sticky();
        rst_n = 0; step(); idle();
        in_valid = 1; in_data = 100;
        repeat (2) step();
        in_valid = 0;
        step();
        checks++;
        if ($signed(shadow_sum) !== 100 || $signed(acc_in) !== 100) begin
            errors++; $display("FAIL sticky_setup shadow=%0d acc_in=%0d want=100,100", $signed(shadow_sum), $signed(acc_in));
        end
        clear_ovf = 1;
        step();
        checks++;
        if (ovf_sticky !== 1 || $signed(shadow_sum) !== -56) begin
            errors++; $display("FAIL sticky_win ovf=%b shadow=%0d want=1,-56", ovf_sticky, $signed(shadow_sum));
        end
        step();
        checks++;
        if (ovf_sticky !== 0 || got !== want()) begin
            errors++; $display("FAIL sticky_clear ovf=%b want=0", ovf_sticky);
        end
        idle();
    endtask

    task automatic test_mid_reset();
        idle();
        in_valid = 1;
        for (int i = 0; i < 3; i++) begin in_data = 8'(40 + i); step(); end
        in_valid = 0; rst_n = 0;
        step();
        checks++;
        if (got !== 22'h000001 || got !== want()) begin errors++; $display("FAIL mid_reset got=%h want=000001", got); end
        rst_n = 1;
        repeat (4) begin
            step();
            checks++;
            if (acc_strobe !== 0 || shadow_sum !== 0 || got !== want()) begin
                errors++; $display("FAIL mid_reset_drop got=%h want=%h", got, want());
            end
        end
    endtask

    task automatic test_random();
        idle();
        for (int i = 0; i < 400; i++) begin
            in_valid = $urandom_range(0, 1);
            in_data = 8'($urandom);
            flush = $urandom_range(0, 15) == 0;
            clear_ovf = $urandom_range(0, 7) == 0;
            rst_n = $urandom_range(0, 63) != 0;
            step();
            checks++;
            if (got !== want()) begin errors++; $display("FAIL random step=%0d got=%h want=%h", i, got, want()); end
        end
        idle();
    endtask

    initial begin
        test_reset();
        test_sequence();
        test_full_flush();
        test_wrap();
        test_sticky();
        test_mid_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
